dmem_responder: RTL and testbench

Memory-side responder for the core's data-memory port. It accepts load/store requests carrying a byte address, an RV32I `funct3` access size and store data. Each request is served from an internal word-organised, little-endian array after a configurable number of wait states. A one-cycle `ready` pulse returns load data sign- or zero-extended per `funct3`. It replaces the zero-latency data memory when the pipeline is run against slower memory.

---
 rtl/dmem_responder.sv | 95 +++++++++
 tb/tb_dmem_responder.sv | 127 ++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: wait-stated, little-endian word memory answering RV32I load/store requests
// Ports:
//   clk, rst                      clock (rising edge), asynchronous active-low reset
//   readEnable, writeEnable       load / store request (store wins when both are high)
//   addr, unitSize, writeData     byte address, funct3 access size, LSB-aligned store data
//   ready                         one-cycle response pulse
//   readData, misaligned          extended load result and error flag, valid with ready
module dmem_responder #(
  parameter int ADDR_SIZE   = 32,
  parameter int WORD_LEN    = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 readEnable,
  input  logic                 writeEnable,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [2:0]           unitSize,
  input  logic [WORD_LEN-1:0]  writeData,
  output logic                 ready,
  output logic [WORD_LEN-1:0]  readData,
  output logic                 misaligned
);
  localparam int IW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;
  stateT state;
  logic [3:0] count;
  logic isWrite, err, illegal;
  logic [IW+1:0] a;
  logic [2:0] u;
  logic [WORD_LEN-1:0] wd, word, loadVal, storeVal;
  logic [WORD_LEN-1:0] mem [DEPTH_WORDS];
  logic [3:0] byteEn;
  logic [7:0] lb;
  logic [15:0] lh;
  // Reserved sizes, misaligned halves/words, and unsigned-size stores are all rejected
  always_comb illegal = unitSize == 3'b011 || unitSize[2:1] == 2'b11 ||
                        (unitSize[1:0] == 2'b01 && addr[0]) ||
                        (unitSize == 3'b010 && addr[1:0] != 2'b00) ||
                        (writeEnable && unitSize[2]);
  // Upper address bits beyond the array are dropped, so addresses wrap
  assign word = mem[a[IW+1:2]];
  always_comb begin
    lb = word[{a[1:0], 3'b000} +: 8];
    lh = a[1] ? word[31:16] : word[15:0];
    loadVal = u[1] ? word : u[0] ? {{16{lh[15] & ~u[2]}}, lh} : {{24{lb[7] & ~u[2]}}, lb};
    byteEn = u[1] ? 4'hF : u[0] ? (a[1] ? 4'hC : 4'h3) : 4'b0001 << a[1:0];
    storeVal = u[1] ? wd : u[0] ? {2{wd[15:0]}} : {4{wd[7:0]}};
  end
  // Array is not reset; a reset during WAIT leaves state IDLE so the store never commits
  always_ff @(posedge clk)
    if (state == RESP && isWrite && !err)
      for (int i = 0; i < 4; i++)
        if (byteEn[i]) mem[a[IW+1:2]][8*i +: 8] <= storeVal[8*i +: 8];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state      <= IDLE;
      count      <= '0;
      ready      <= 1'b0;
      readData   <= '0;
      misaligned <= 1'b0;
      isWrite    <= 1'b0;
      err        <= 1'b0;
      a          <= '0;
      u          <= '0;
      wd         <= '0;
    end else begin
      ready      <= 1'b0;
      readData   <= '0;
      misaligned <= 1'b0;
      case (state)
        IDLE: if (readEnable || writeEnable) begin
          a       <= addr[IW+1:0];
          u       <= unitSize;
          wd      <= writeData;
          isWrite <= writeEnable;
          err     <= illegal;
          count   <= 4'(WAIT_STATES);
          state   <= (illegal || WAIT_STATES == 0) ? RESP : WAIT;
        end
        WAIT: begin
          count <= count - 4'd1;
          if (count == 4'd1) state <= RESP;
        end
        RESP: begin
          ready      <= 1'b1;
          misaligned <= err;
          readData   <= (err || isWrite) ? '0 : loadVal;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized and directed checks of two responders against a byte-level memory model
module tb_dmem_responder;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst [2], re [2], we [2], rdy [2], mis [2];
  logic [31:0] addr [2], wdat [2], rdat [2];
  logic [2:0] unit [2];
  logic [7:0] mb [2][4096];
  logic [31:0] g;
  int checks = 0, failures = 0;

  dmem_responder #(.WAIT_STATES(1)) dut0 (.clk(clk), .rst(rst[0]), .readEnable(re[0]), .writeEnable(we[0]),
    .addr(addr[0]), .unitSize(unit[0]), .writeData(wdat[0]), .ready(rdy[0]), .readData(rdat[0]), .misaligned(mis[0]));
  dmem_responder #(.WAIT_STATES(3)) dut1 (.clk(clk), .rst(rst[1]), .readEnable(re[1]), .writeEnable(we[1]),
    .addr(addr[1]), .unitSize(unit[1]), .writeData(wdat[1]), .ready(rdy[1]), .readData(rdat[1]), .misaligned(mis[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int wsOf(input int d);
    return d ? 3 : 1;
  endfunction

  function automatic int sizeOf(input logic [2:0] u);
    case (u)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  task automatic req(input int d, input bit w, input logic [31:0] a, input logic [2:0] u,
                     input logic [31:0] wd, output logic [31:0] got);
    int n, cyc, base;
    bit bad;
    logic [31:0] exp;
    n = sizeOf(u);
    base = int'(a[11:0]);
    bad = n == 0 || (int'(a[1:0]) % n) != 0 || (w && u[2]);
    exp = 0;
    if (!bad && !w) begin
      for (int i = 0; i < n; i++) exp |= 32'(mb[d][base + i]) << (8 * i);
      if (!u[2] && n < 4 && exp[8*n-1]) exp |= 32'hFFFF_FFFF << (8 * n);
    end
    we[d] = w; re[d] = !w; addr[d] = a; unit[d] = u; wdat[d] = wd;
    @(posedge clk);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!rdy[d] && cyc < 40);
    got = rdat[d];
    we[d] = 0; re[d] = 0;
    chk($sformatf("latency d%0d a=%h u=%0d", d, a, u), 32'(cyc), 32'(bad ? 1 : wsOf(d) + 1));
    chk($sformatf("ready d%0d a=%h", d, a), 32'(rdy[d]), 1);
    chk($sformatf("readData d%0d a=%h u=%0d w=%0d", d, a, u, w), rdat[d], exp);
    chk($sformatf("misaligned d%0d a=%h u=%0d", d, a, u), 32'(mis[d]), 32'(bad));
    if (!bad && w)
      for (int i = 0; i < n; i++) mb[d][base + i] = 8'(wd >> (8 * i));
    @(posedge clk); #1;
    chk($sformatf("pulse d%0d", d), 32'(rdy[d]), 0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 0; re[d] = 0; we[d] = 0; addr[d] = 0; unit[d] = 0; wdat[d] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++)
      chk($sformatf("reset d%0d", d), {rdy[d], mis[d], rdat[d][29:0]}, 0);
    @(negedge clk);
    rst[0] = 1; rst[1] = 1;
    @(negedge clk);
    for (int d = 0; d < 2; d++)
      for (int i = 0; i <= 16; i++) req(d, 1, 32'(i * 4), 3'd2, $urandom, g);
    req(0, 1, 32'h10, 3'd2, 32'h8000_00F0, g);
    req(0, 0, 32'h10, 3'd2, 0, g);             chk("LW 0x10", g, 32'h8000_00F0);
    req(0, 1, 32'h20, 3'd2, 32'h80FF_7F80, g);
    req(0, 0, 32'h20, 3'd0, 0, g);             chk("LB 0x20", g, 32'hFFFF_FF80);
    req(0, 0, 32'h20, 3'd4, 0, g);             chk("LBU 0x20", g, 32'h0000_0080);
    req(0, 0, 32'h21, 3'd0, 0, g);             chk("LB 0x21", g, 32'h0000_007F);
    req(0, 0, 32'h22, 3'd1, 0, g);             chk("LH 0x22", g, 32'hFFFF_80FF);
    req(0, 0, 32'h22, 3'd5, 0, g);             chk("LHU 0x22", g, 32'h0000_80FF);
    req(0, 1, 32'h30, 3'd2, 32'h1111_1111, g);
    req(0, 1, 32'h31, 3'd0, 32'h0000_00AB, g);
    req(0, 1, 32'h32, 3'd1, 32'h0000_CDEF, g);
    req(0, 0, 32'h30, 3'd2, 0, g);             chk("LW 0x30", g, 32'hCDEF_AB11);
    req(0, 0, 32'h12, 3'd2, 0, g);
    req(0, 1, 32'h13, 3'd1, 32'hFFFF_FFFF, g);
    req(0, 1, 32'h10, 3'd4, 32'hFFFF_FFFF, g);
    req(0, 0, 32'h10, 3'd3, 0, g);
    req(0, 0, 32'h10, 3'd2, 0, g);             chk("LW 0x10 after illegal", g, 32'h8000_00F0);
    req(0, 1, 32'h1004, 3'd2, 32'hDEAD_BEEF, g);
    req(0, 0, 32'h0004, 3'd2, 0, g);           chk("LW 0x4 wrap", g, 32'hDEAD_BEEF);
    req(1, 1, 32'h40, 3'd2, 32'h1234_5678, g);
    we[1] = 1; addr[1] = 32'h40; unit[1] = 3'd2; wdat[1] = 32'h5555_5555;
    @(posedge clk);
    @(posedge clk); #1;
    rst[1] = 0; we[1] = 0;
    repeat (5) begin
      @(posedge clk); #1;
      chk("in reset outputs", {rdy[1], mis[1], rdat[1][29:0]}, 0);
    end
    @(negedge clk);
    rst[1] = 1;
    repeat (6) begin
      @(posedge clk); #1;
      chk("after reset ready", {rdy[1], mis[1], rdat[1][29:0]}, 0);
    end
    req(1, 0, 32'h40, 3'd2, 0, g);             chk("LW 0x40 after reset", g, 32'h1234_5678);
    repeat (80) begin
      int d;
      d = int'($urandom_range(0, 1));
      req(d, ($urandom % 3) == 0, ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63)),
          3'($urandom_range(0, 7)), $urandom, g);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
